h264invdctransform: RTL and testbench

//  Inverse 2x2 chroma DC Hadamard for the encoder reconstruction path. It is the decode-side

---
 rtl/h264_xform_pkg.sv | 22 ++
 rtl/h264_hadamard2x2.sv | 34 +++
 rtl/h264invdctransform.sv | 75 +++++++
 tb/tb_h264invdctransform.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/h264_xform_pkg.sv
// rtl/h264_xform_pkg.sv - shared types and saturation helper for the chroma DC inverse transform
package h264_xform_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  typedef logic signed [15:0] coef_t;
  typedef logic signed [17:0] acc_t;

  function automatic coef_t sat16(input acc_t a);
    if (a > 18'sd32767)
      return 16'sh7fff;
    else if (a < -18'sd32768)
      return 16'sh8000;
    else
      return a[15:0];
  endfunction

endpackage

// File: rtl/h264_hadamard2x2.sv
// rtl/h264_hadamard2x2.sv - combinational 2x2 Hadamard butterfly with 18-bit headroom
module h264_hadamard2x2
  import h264_xform_pkg::*;
(
  input  coef_t c00,
  input  coef_t c01,
  input  coef_t c10,
  input  coef_t c11,
  output acc_t  f00,
  output acc_t  f01,
  output acc_t  f10,
  output acc_t  f11
);

  acc_t a00, a01, a10, a11;
  acc_t s0, d0, s1, d1;

  assign a00 = acc_t'(c00);
  assign a01 = acc_t'(c01);
  assign a10 = acc_t'(c10);
  assign a11 = acc_t'(c11);

  // Row butterflies first, then column butterflies.
  assign s0 = a00 + a01;
  assign d0 = a00 - a01;
  assign s1 = a10 + a11;
  assign d1 = a10 - a11;

  assign f00 = s0 + s1;
  assign f01 = d0 + d1;
  assign f10 = s0 - s1;
  assign f11 = d0 - d1;

endmodule

// File: rtl/h264invdctransform.sv
// rtl/h264invdctransform.sv - serial inverse 2x2 chroma DC transform: collect 4, compute, emit 4
module h264invdctransform
  import h264_xform_pkg::*;
#(
  parameter int OUT_SHIFT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        READYI,
  input  logic        ENABLE,
  input  logic [15:0] XXIN,
  output logic        VALID,
  output logic [15:0] YYOUT,
  input  logic        READYO
);

  state_t      state_q, state_d;
  logic [1:0]  in_cnt, out_cnt;
  coef_t       c_q [4];
  coef_t       f_q [4];
  acc_t        h00, h01, h10, h11;

  h264_hadamard2x2 u_hadamard (
    .c00 (c_q[0]),
    .c01 (c_q[1]),
    .c10 (c_q[2]),
    .c11 (c_q[3]),
    .f00 (h00),
    .f01 (h01),
    .f10 (h10),
    .f11 (h11)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (ENABLE && in_cnt == 2'd3) state_d = COMPUTE;
      COMPUTE: state_d = EMIT;
      EMIT:    if (READYO && out_cnt == 2'd3) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Handshake flags are pure state decodes so they are correct during reset.
  assign READYI = (state_q == COLLECT);
  assign VALID  = (state_q == EMIT);
  assign YYOUT  = f_q[out_cnt];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= COLLECT;
      in_cnt  <= 2'd0;
      out_cnt <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        c_q[i] <= '0;
        f_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == COLLECT && ENABLE) begin
        c_q[in_cnt] <= XXIN;
        in_cnt      <= in_cnt + 2'd1;
      end
      if (state_q == COMPUTE) begin
        f_q[0] <= sat16(h00 >>> OUT_SHIFT);
        f_q[1] <= sat16(h01 >>> OUT_SHIFT);
        f_q[2] <= sat16(h10 >>> OUT_SHIFT);
        f_q[3] <= sat16(h11 >>> OUT_SHIFT);
      end
      if (state_q == EMIT && READYO)
        out_cnt <= out_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_h264invdctransform.sv
// tb/tb_h264invdctransform.sv - self-checking bench for h264invdctransform
module tb_h264invdctransform;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] XXIN;
  logic        READYO;
  logic        READYI0, VALID0, READYI1, VALID1;
  logic [15:0] YYOUT0, YYOUT1;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  h264invdctransform #(.OUT_SHIFT(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .READYI(READYI0), .ENABLE(ENABLE),
    .XXIN(XXIN), .VALID(VALID0), .YYOUT(YYOUT0), .READYO(READYO)
  );

  h264invdctransform #(.OUT_SHIFT(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READYI(READYI1), .ENABLE(ENABLE),
    .XXIN(XXIN), .VALID(VALID1), .YYOUT(YYOUT1), .READYO(READYO)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: f[k] = sum over n of c[n] * (-1)^popcount(k & n), then shift and clamp.
  function automatic logic [15:0] model(input logic [15:0] w[4], input int k, input int sh);
    int acc = 0;
    for (int n = 0; n < 4; n++) begin
      int v = int'($signed(w[n]));
      if ($countones(k & n) % 2 == 1) acc -= v;
      else acc += v;
    end
    acc = acc >>> sh;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic send(input logic [15:0] w[4], input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap == i) begin
        ENABLE = 1'b0;
        XXIN   = 16'(($urandom));
        @(negedge CLK);
        chk("readyi_gap", {15'd0, READYI0}, 16'd1);
      end
      ENABLE = 1'b1;
      XXIN   = w[i];
      chk("readyi_in", {15'd0, READYI0}, 16'd1);
      @(negedge CLK);
    end
    // Junk words offered while busy must be ignored.
    XXIN = 16'(($urandom));
    chk("readyi_compute", {15'd0, READYI0}, 16'd0);
  endtask

  task automatic receive(input logic [15:0] w[4], input int stall);
    int t = 0;
    while (VALID0 !== 1'b1 && t < 4) begin
      @(negedge CLK);
      XXIN = 16'(($urandom));
      t++;
    end
    chk("valid_rise", {15'd0, VALID0}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("y0_%0d", k), YYOUT0, model(w, k, 0));
      chk($sformatf("y1_%0d", k), YYOUT1, model(w, k, 1));
      chk("valid_out", {15'd0, VALID0}, 16'd1);
      chk("readyi_out", {15'd0, READYI0}, 16'd0);
      if (k == 0 && stall > 0) begin
        READYO = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge CLK);
          chk("hold_y", YYOUT0, model(w, 0, 0));
          chk("hold_valid", {15'd0, VALID0}, 16'd1);
          chk("hold_readyi", {15'd0, READYI0}, 16'd0);
        end
        READYO = 1'b1;
      end
      @(negedge CLK);
      if (k == 3) ENABLE = 1'b0;
    end
    chk("valid_fall", {15'd0, VALID0}, 16'd0);
    chk("readyi_back", {15'd0, READYI0}, 16'd1);
  endtask

  initial begin
    logic [15:0] g[4];
    RESET  = 1'b1;
    ENABLE = 1'b0;
    XXIN   = 16'd0;
    READYO = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_valid", {15'd0, VALID0}, 16'd0);
    chk("rst_yyout", YYOUT0, 16'd0);
    chk("rst_readyi", {15'd0, READYI0}, 16'd1);
    RESET = 1'b0;
    @(negedge CLK);

    g = '{16'd1, 16'd2, 16'd3, 16'd4};
    send(g, -1);
    receive(g, 0);
    chk("t1_f00", model(g, 0, 0), 16'h000a);
    chk("t6_f01", model(g, 1, 1), 16'hffff);

    g = '{16'd5, 16'd6, 16'd7, 16'd8};
    send(g, 2);
    receive(g, 0);

    g = '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff};
    send(g, -1);
    receive(g, 0);
    g = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    send(g, -1);
    receive(g, 0);

    g = '{16'd1, 16'd2, 16'd3, 16'd4};
    send(g, -1);
    receive(g, 3);

    // Reset while the second output word is presented.
    send(g, -1);
    @(negedge CLK);
    chk("t5_valid", {15'd0, VALID0}, 16'd1);
    @(negedge CLK);
    chk("t5_second", YYOUT0, 16'hfffe);
    RESET = 1'b1;
    #1;
    chk("t5_rst_valid", {15'd0, VALID0}, 16'd0);
    chk("t5_rst_yyout", YYOUT0, 16'd0);
    chk("t5_rst_readyi", {15'd0, READYI0}, 16'd1);
    ENABLE = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    send(g, -1);
    receive(g, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) g[i] = 16'(($urandom));
      send(g, int'($urandom_range(0, 4)));
      receive(g, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
